// File: rtl/jt053244_drq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jt053244_drq: draw-request FIFO and start/busy scheduler between the      |
// | k053244 scanner and the line drawer. Optional: JT053244_DRQ_STATS_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jt053244_drq #(
  parameter int DEPTH = 4,
  parameter int CW    = 52,
  parameter int TOUT  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   hs,
  input  logic                   in_start,
  input  logic [CW-1:0]          in_cmd,
  output logic                   in_busy,
  output logic                   dr_start,
  output logic [CW-1:0]          dr_cmd,
  input  logic                   dr_busy,
  output logic [$clog2(DEPTH):0] qlevel,
  output logic                   ovf
`ifdef JT053244_DRQ_STATS_EN
  ,
  input  logic [7:0]             st_addr,
  output logic [7:0]             st_dout
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;
  localparam int TW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [CW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [QW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_inc;
  state_t        state_q;
  logic          dr_start_q, in_busy_q, ovf_q, hs_q;
  logic [CW-1:0] dr_cmd_q;
  logic          flush, full, empty, do_wr, do_drop, do_pop;

  // Fullness is judged on the pre-update count, so a same-cycle pop never frees a slot.
  always_comb begin
    flush    = hs & ~hs_q;
    full     = (cnt_q == QW'(DEPTH));
    empty    = (cnt_q == '0);
    do_wr    = in_start & ~full & ~flush;
    do_drop  = in_start & full & ~flush;
    do_pop   = (state_q == IDLE) & ~empty & ~dr_busy & ~flush;
    tcnt_inc = tcnt_q + TW'(1);
    cnt_d    = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (do_wr && !do_pop)
      cnt_d = cnt_q + QW'(1);
    else if (!do_wr && do_pop)
      cnt_d = cnt_q - QW'(1);
  end

  always_ff @(posedge clk) begin
    if (cen && do_wr)
      mem_q[wptr_q] <= in_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      state_q    <= IDLE;
      dr_start_q <= 1'b0;
      dr_cmd_q   <= '0;
      in_busy_q  <= 1'b0;
      ovf_q      <= 1'b0;
      hs_q       <= 1'b0;
    end else if (cen) begin
      hs_q      <= hs;
      cnt_q     <= cnt_d;
      in_busy_q <= (cnt_d == QW'(DEPTH));
      ovf_q     <= flush ? 1'b0 : (ovf_q | do_drop);
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (do_wr)  wptr_q <= wptr_q + PW'(1);
        if (do_pop) rptr_q <= rptr_q + PW'(1);
      end
      // A flush never aborts the handshake already under way.
      case (state_q)
        IDLE: begin
          if (do_pop) begin
            dr_cmd_q   <= mem_q[rptr_q];
            dr_start_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          dr_start_q <= 1'b0;
          tcnt_q     <= '0;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (dr_busy) begin
            state_q <= WAIT_DONE;
          end else begin
            tcnt_q <= tcnt_inc;
            if (tcnt_inc == TW'(TOUT))
              state_q <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!dr_busy)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_busy  = in_busy_q;
  assign dr_start = dr_start_q;
  assign dr_cmd   = dr_cmd_q;
  assign qlevel   = cnt_q;
  assign ovf      = ovf_q;

`ifdef JT053244_DRQ_STATS_EN
  logic [7:0]    drops_q, iss_cur_q, iss_last_q, st_dout_q;
  logic [QW-1:0] peak_cur_q, peak_last_q;
  logic          unused_st_addr;

  assign unused_st_addr = ^st_addr[7:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      drops_q     <= '0;
      iss_cur_q   <= '0;
      iss_last_q  <= '0;
      peak_cur_q  <= '0;
      peak_last_q <= '0;
      st_dout_q   <= '0;
    end else begin
      case (st_addr[1:0])
        2'd0:    st_dout_q <= drops_q;
        2'd1:    st_dout_q <= iss_last_q;
        2'd2:    st_dout_q <= 8'(peak_last_q);
        default: st_dout_q <= {ovf_q, state_q, 5'(cnt_q)};
      endcase
      if (cen) begin
        if (flush) begin
          drops_q     <= '0;
          iss_last_q  <= iss_cur_q;
          iss_cur_q   <= '0;
          peak_last_q <= peak_cur_q;
          peak_cur_q  <= '0;
        end else begin
          if (do_drop && drops_q != 8'hff)  drops_q   <= drops_q + 8'd1;
          if (do_pop && iss_cur_q != 8'hff) iss_cur_q <= iss_cur_q + 8'd1;
          if (cnt_d > peak_cur_q)           peak_cur_q <= cnt_d;
        end
      end
    end
  end

  assign st_dout = st_dout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt053244_drq.sv
`default_nettype none
// Scoreboard bench for jt053244_drq: expected commands queued at write time, compared against captured dr_start issues.
module tb_jt053244_drq;
  localparam int DEPTH = 4;
  localparam int CW    = 52;
  localparam int TOUT  = 3;

  logic          clk = 1'b0;
  logic          rst, cen, hs, in_start, dr_busy;
  logic [CW-1:0] in_cmd, dr_cmd;
  logic          in_busy, dr_start, ovf;
  logic [2:0]    qlevel;
`ifdef JT053244_DRQ_STATS_EN
  logic [7:0]    st_addr = 8'd0;
  logic [7:0]    st_dout;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  int   model_len = 0;
  int   bcnt = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got_cmd[$];
  int            got_cyc[$];

  jt053244_drq #(.DEPTH(DEPTH), .CW(CW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .hs(hs),
    .in_start(in_start), .in_cmd(in_cmd), .in_busy(in_busy),
    .dr_start(dr_start), .dr_cmd(dr_cmd), .dr_busy(dr_busy),
    .qlevel(qlevel), .ovf(ovf)
`ifdef JT053244_DRQ_STATS_EN
    , .st_addr(st_addr), .st_dout(st_dout)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cen) cyc <= cyc + 1;

  // Drawer model: busy for model_len cen cycles after each start (0 = never busy).
  always @(negedge clk) begin
    if (rst) bcnt = 0;
    else if (cen) begin
      if (dr_start && model_len > 0) bcnt = model_len;
      else if (bcnt > 0) bcnt = bcnt - 1;
    end
    model_busy = (bcnt > 0);
  end
  assign dr_busy = force_busy | model_busy;

  always @(negedge clk) begin
    if (!rst && cen && dr_start) begin
      got_cmd.push_back(dr_cmd);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [CW-1:0] mk(input logic [15:0] code);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {r[CW-1:16], code};
  endfunction

  task automatic wr(input logic [CW-1:0] c);
    in_start = 1'b1; in_cmd = c;
    tick();
    in_start = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete(); got_cmd.delete(); got_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; hs = 1'b0; in_start = 1'b0; in_cmd = '0;
    repeat (3) tick();
    checks++; if (dr_start !== 1'b0) begin errors++; $display("FAIL reset_dr_start got %b exp 0", dr_start); end
    checks++; if (dr_cmd !== '0) begin errors++; $display("FAIL reset_dr_cmd got %h exp 0", dr_cmd); end
    checks++; if (in_busy !== 1'b0) begin errors++; $display("FAIL reset_in_busy got %b exp 0", in_busy); end
    checks++; if (qlevel !== 3'd0) begin errors++; $display("FAIL reset_qlevel got %0d exp 0", qlevel); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst = 1'b0;
    tick();
    clear_q();
  endtask

  task automatic test_single();
    logic [CW-1:0] c, g;
    int stamp;
    model_len = 10;
    c = mk(16'h1234);
    stamp = cyc;
    exp_q.push_back(c);
    wr(c);
    for (int i = 0; i < 20 && got_cmd.size() < 1; i++) tick();
    checks++; if (got_cmd.size() < 1) begin errors++; $display("FAIL single_issue got %0d starts exp 1", got_cmd.size()); end
    else begin
      checks++; if (got_cyc[0] !== stamp + 2) begin errors++; $display("FAIL single_latency got %0d exp %0d", got_cyc[0] - stamp, 2); end
    end
    repeat (30) tick();
    checks++; if (got_cmd.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_cmd.size()); end
    checks++; if (qlevel !== 3'd0) begin errors++; $display("FAIL single_qlevel got %0d exp 0", qlevel); end
    while (exp_q.size() > 0 && got_cmd.size() > 0) begin
      c = exp_q.pop_front(); g = got_cmd.pop_front();
      checks++; if (g !== c) begin errors++; $display("FAIL single_cmd got %h exp %h", g, c); end
    end
    clear_q();
  endtask

  task automatic test_overflow();
    logic [CW-1:0] c, g;
    force_busy = 1'b1; model_len = 3;
    for (int i = 0; i < 6; i++) begin
      c = mk(16'h0100 + 16'(i));
      if (i < 4) exp_q.push_back(c);
      in_start = 1'b1; in_cmd = c;
      tick();
      if (i == 3) begin
        checks++; if (in_busy !== 1'b1) begin errors++; $display("FAIL ovf_in_busy got %b exp 1", in_busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf); end
      end
    end
    in_start = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    checks++; if (qlevel !== 3'd4) begin errors++; $display("FAIL ovf_qlevel got %0d exp 4", qlevel); end
    checks++; if (got_cmd.size() !== 0) begin errors++; $display("FAIL ovf_held got %0d starts exp 0", got_cmd.size()); end
    force_busy = 1'b0;
    for (int i = 0; i < 100 && got_cmd.size() < 4; i++) tick();
    repeat (20) tick();
    checks++; if (got_cmd.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d exp 4", got_cmd.size()); end
    checks++; if (in_busy !== 1'b0) begin errors++; $display("FAIL ovf_in_busy_end got %b exp 0", in_busy); end
    while (exp_q.size() > 0 && got_cmd.size() > 0) begin
      c = exp_q.pop_front(); g = got_cmd.pop_front();
      checks++; if (g !== c) begin errors++; $display("FAIL ovf_order got %h exp %h", g, c); end
    end
    clear_q();
  endtask

  task automatic test_flush();
    logic [CW-1:0] c, g;
    model_len = 10;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got %b exp 1", ovf); end
    for (int i = 0; i < 4; i++) begin
      c = mk(16'h0200 + 16'(i));
      if (i == 0) exp_q.push_back(c);
      wr(c);
    end
    repeat (2) tick();
    checks++; if (qlevel !== 3'd3) begin errors++; $display("FAIL flush_pre_qlevel got %0d exp 3", qlevel); end
    hs = 1'b1; in_start = 1'b1; in_cmd = mk(16'h02ff);
    tick();
    in_start = 1'b0;
    checks++; if (qlevel !== 3'd0) begin errors++; $display("FAIL flush_qlevel got %0d exp 0", qlevel); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b exp 0", ovf); end
    tick();
    hs = 1'b0;
    repeat (40) tick();
    checks++; if (got_cmd.size() !== 1) begin errors++; $display("FAIL flush_count got %0d exp 1", got_cmd.size()); end
    checks++; if (qlevel !== 3'd0) begin errors++; $display("FAIL flush_qlevel_end got %0d exp 0", qlevel); end
    while (exp_q.size() > 0 && got_cmd.size() > 0) begin
      c = exp_q.pop_front(); g = got_cmd.pop_front();
      checks++; if (g !== c) begin errors++; $display("FAIL flush_cmd got %h exp %h", g, c); end
    end
    clear_q();
  endtask

  task automatic test_spacing();
    logic [CW-1:0] c, g;
    int stamp;
    model_len = 0;
    stamp = cyc;
    for (int i = 0; i < 3; i++) begin
      c = mk(16'h0300 + 16'(i));
      exp_q.push_back(c);
      wr(c);
    end
    for (int i = 0; i < 40 && got_cmd.size() < 3; i++) tick();
    repeat (10) tick();
    checks++; if (got_cmd.size() !== 3) begin errors++; $display("FAIL space_count got %0d exp 3", got_cmd.size()); end
    else begin
      checks++; if (got_cyc[0] !== stamp + 2) begin errors++; $display("FAIL space_first got %0d exp %0d", got_cyc[0] - stamp, 2); end
      checks++; if (got_cyc[1] - got_cyc[0] !== 5) begin errors++; $display("FAIL space_gap1 got %0d exp 5", got_cyc[1] - got_cyc[0]); end
      checks++; if (got_cyc[2] - got_cyc[1] !== 5) begin errors++; $display("FAIL space_gap2 got %0d exp 5", got_cyc[2] - got_cyc[1]); end
    end
    while (exp_q.size() > 0 && got_cmd.size() > 0) begin
      c = exp_q.pop_front(); g = got_cmd.pop_front();
      checks++; if (g !== c) begin errors++; $display("FAIL space_cmd got %h exp %h", g, c); end
    end
    clear_q();
  endtask

  task automatic test_full_pop();
    logic [CW-1:0] c, g;
    force_busy = 1'b1; model_len = 0;
    for (int i = 0; i < 4; i++) begin
      c = mk(16'h0400 + 16'(i));
      exp_q.push_back(c);
      wr(c);
    end
    checks++; if (in_busy !== 1'b1) begin errors++; $display("FAIL fullpop_in_busy got %b exp 1", in_busy); end
    force_busy = 1'b0;
    in_start = 1'b1; in_cmd = mk(16'h04ee);
    tick();
    in_start = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got %b exp 1", ovf); end
    checks++; if (qlevel !== 3'd3) begin errors++; $display("FAIL fullpop_qlevel got %0d exp 3", qlevel); end
    c = mk(16'h0405);
    exp_q.push_back(c);
    wr(c);
    checks++; if (qlevel !== 3'd4) begin errors++; $display("FAIL fullpop_accept got %0d exp 4", qlevel); end
    for (int i = 0; i < 60 && got_cmd.size() < 5; i++) tick();
    repeat (10) tick();
    checks++; if (got_cmd.size() !== 5) begin errors++; $display("FAIL fullpop_count got %0d exp 5", got_cmd.size()); end
    while (exp_q.size() > 0 && got_cmd.size() > 0) begin
      c = exp_q.pop_front(); g = got_cmd.pop_front();
      checks++; if (g !== c) begin errors++; $display("FAIL fullpop_cmd got %h exp %h", g, c); end
    end
    clear_q();
  endtask

  task automatic test_cen_hold();
    logic [CW-1:0] c;
    model_len = 0;
    c = mk(16'h0500);
    wr(c);
    tick();
    checks++; if (dr_start !== 1'b1) begin errors++; $display("FAIL cen_start got %b exp 1", dr_start); end
    cen = 1'b0;
    repeat (3) tick();
    checks++; if (dr_start !== 1'b1) begin errors++; $display("FAIL cen_hold_start got %b exp 1", dr_start); end
    checks++; if (dr_cmd !== c) begin errors++; $display("FAIL cen_hold_cmd got %h exp %h", dr_cmd, c); end
    cen = 1'b1;
    tick();
    checks++; if (dr_start !== 1'b0) begin errors++; $display("FAIL cen_pulse_end got %b exp 0", dr_start); end
    repeat (15) tick();
    checks++; if (got_cmd.size() !== 1) begin errors++; $display("FAIL cen_count got %0d exp 1", got_cmd.size()); end
    clear_q();
  endtask

  task automatic test_rst_mid();
    logic [CW-1:0] c, g;
    int stamp;
    model_len = 10;
    for (int i = 0; i < 3; i++) wr(mk(16'h0600 + 16'(i)));
    repeat (3) tick();
    checks++; if (qlevel !== 3'd2) begin errors++; $display("FAIL rstmid_pre_qlevel got %0d exp 2", qlevel); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (qlevel !== 3'd0) begin errors++; $display("FAIL rstmid_qlevel got %0d exp 0", qlevel); end
    checks++; if (dr_start !== 1'b0) begin errors++; $display("FAIL rstmid_dr_start got %b exp 0", dr_start); end
    clear_q();
    model_len = 0;
    c = mk(16'h06aa);
    exp_q.push_back(c);
    stamp = cyc;
    wr(c);
    for (int i = 0; i < 20 && got_cmd.size() < 1; i++) tick();
    checks++; if (got_cmd.size() !== 1) begin errors++; $display("FAIL rstmid_issue got %0d exp 1", got_cmd.size()); end
    else begin
      checks++; if (got_cyc[0] !== stamp + 2) begin errors++; $display("FAIL rstmid_latency got %0d exp 2", got_cyc[0] - stamp); end
    end
    while (exp_q.size() > 0 && got_cmd.size() > 0) begin
      c = exp_q.pop_front(); g = got_cmd.pop_front();
      checks++; if (g !== c) begin errors++; $display("FAIL rstmid_cmd got %h exp %h", g, c); end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_flush();
    test_spacing();
    test_full_pop();
    test_cen_hold();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jt053244_drq.md
Name: jt053244_drq

Overview:
- Draw-request queue and scheduler placed between the k053244 sprite-table scanner and the line drawer (indr / 051937 path).
- Buffers draw commands so the scanner keeps evaluating objects while the drawer is busy.
- Issues commands to the drawer with a start/busy handshake.
- Flushes stale commands at every line start.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2 to 16.
- CW, 52: command width. Packing, MSB to LSB: shd, hz_keep, hzoom[11:0], ysub[3:0], hpos[8:0], vflip, hflip, attr[6:0], code[15:0].
- TOUT, 3: cen cycles to wait for drawer busy to rise after a start before the start is treated as acknowledged.

Ports:
- clk input 1: system clock.
- rst input 1: synchronous, active-high reset.
- cen input 1: clock enable. All state advances only when cen=1.
- hs input 1: horizontal sync. The rising edge, sampled on cen, starts a new line.
- in_start input 1: scanner command strobe, one cen cycle wide.
- in_cmd input CW: scanner command, valid while in_start=1.
- in_busy output 1: FIFO full. The scanner must hold off.
- dr_start output 1: drawer start pulse, exactly one cen cycle wide.
- dr_cmd output CW: command presented to the drawer. Held stable from dr_start until the next issue.
- dr_busy input 1: drawer busy.
- qlevel output $clog2(DEPTH)+1: current FIFO occupancy.
- ovf output 1: sticky flag, set on any dropped write; cleared by reset or by a line flush.

Behaviour:
- Clocking: a single clock (clk). rst is synchronous and active-high, and takes effect on the clk edge regardless of cen.
- Reset values: dr_start=0, dr_cmd=0, in_busy=0, qlevel=0, ovf=0. Pointers are 0, the FSM is in IDLE, and the hs history bit is 0.
- Write path:
  - On cen with in_start=1 and FIFO not full, in_cmd is stored at the write pointer and the pointer increments modulo DEPTH.
  - If the FIFO is full, the write is dropped and ovf is set.
  - Fullness is evaluated before any same-cycle read. There is no bypass and no read-frees-slot on the same cycle.
- in_busy is registered: in_busy = (occupancy == DEPTH) after the update of the current cen cycle.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if the FIFO is non-empty and dr_busy=0, pop the head into dr_cmd, then go to ISSUE.
  - ISSUE: dr_start=1 for this cen cycle only. Clear the timeout counter. Go to WAIT_ACK.
  - WAIT_ACK:
    - If dr_busy=1, go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches TOUT, go to IDLE; the drawer is taken to have completed instantly.
  - WAIT_DONE: when dr_busy=0, go to IDLE.
- Latency:
  - The first command written into an empty queue with the drawer idle reaches dr_start 2 cen cycles after the write: write, then pop in IDLE, then ISSUE.
  - The minimum spacing between successive dr_start pulses is 3 cen cycles when the drawer never raises busy: ISSUE, then WAIT_ACK timing out when TOUT=1, then IDLE pop.
- Line flush: on cen with hs=1 and the previous hs=0:
  - Read and write pointers are reset, qlevel=0, and ovf is cleared.
  - An in_start on the same cycle is dropped and does not set ovf.
  - A pop on the same cycle is suppressed.
  - The FSM is not aborted. An in-flight command (ISSUE, WAIT_ACK or WAIT_DONE) completes its handshake; a later IDLE then sees the queue empty.
- dr_busy already high in IDLE: no pop. Wait for it to fall; a drawer held by another source blocks issue.
- Pointers wrap modulo DEPTH. Occupancy is kept as an explicit counter, 0 to DEPTH, to distinguish full from empty.
- cen=0: all outputs hold, including dr_start; the pulse width is counted in cen cycles.

Optional Feature:
- Macro: JT053244_DRQ_STATS_EN.
- With the macro defined, the block adds:
  - Ports st_addr input [7:0] and st_dout output [7:0].
  - An 8-bit saturating count of drops since the last flush.
  - An 8-bit saturating count of commands issued in the last completed line, latched at flush.
  - Peak occupancy of the last completed line, latched at flush.
  - st_addr[1:0] selects the readout, registered by one clk: 0 = drops, 1 = issued, 2 = peak, 3 = {ovf, state[1:0], qlevel zero-extended to 5 bits}.
- Without the macro, these ports and counters are absent, and the queue behaves identically.

Test Plan:
- Reset, then a single in_start with code=16'h1234 and the drawer model busy for 10 cen → dr_start appears 2 cen later with dr_cmd code=16'h1234. No second dr_start until 1 cen after busy falls. qlevel returns to 0.
- Drawer held busy, DEPTH=4, 6 back-to-back writes → in_busy=1 after the 4th write, writes 5 and 6 dropped, ovf=1. After release, dr_start fires exactly 4 times, with commands in write order.
- Drawer never raises busy, TOUT=3, 3 queued commands → dr_start pulses spaced 5 cen apart, all 3 issued.
- hs rising edge while 3 entries are queued and one is in WAIT_DONE, plus in_start on the same cycle → qlevel=0, ovf=0, the in-flight handshake completes, and no further dr_start occurs.
- Full FIFO with a pop and an in_start on the same cen → the write is dropped and ovf=1; the next write is accepted.
- rst asserted mid-WAIT_DONE with the FIFO non-empty → next cycle: qlevel=0, dr_start=0, IDLE; a subsequent write is issued normally.
